// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes,
// opcodes, ALUOp / operand-select encodings and an opcode support check.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_out_decode.sv
// Combinational output decode for the control FSM: current state plus the
// (reset-gated) memory ready flag mapped onto the datapath strobes.
module multicycle_ctrl_out_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic        mem_ready,
  input  logic [5:0]  opcode,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        instr_done,
  output logic        illegal_op
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_RT;
    alu_op        = ALUOP_ADD;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        // PC+4 and IR load only once the instruction word has arrived
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = ALUB_IMM_SH2;
        illegal_op = !op_supported(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: holds the state register
// and next-state logic; strobes come from the output decode sub-module.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);

  state_t state_reg;
  state_t state_next;
  logic   ready_gated;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_RWB;
      S_ADDIEX: state_next = S_ADDIWB;
      default:  state_next = S_FETCH;
    endcase
  end

  // While reset is held no PC or IR update may slip through on mem_ready
  assign ready_gated = mem_ready & rstn;

  multicycle_ctrl_out_decode u_out_decode (
    .state         (state_reg),
    .mem_ready     (ready_gated),
    .opcode        (opcode),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

  assign dbg_state = STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: one task per scenario,
// inputs driven at the falling edge, outputs sampled 1 ns later.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
    .dbg_state(dbg_state)
  );

  task automatic test_reset();
    rstn = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (dbg_state !== 4'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    n_cmp++;
    if ({mem_read, i_or_d, alu_src_b, pc_write, ir_write} !== 6'b10_0100) begin
      n_err++;
      $display("FAIL reset_fetch_out got=%b exp=100100", {mem_read, i_or_d, alu_src_b, pc_write, ir_write});
    end
    @(negedge clk);
    rstn = 1'b1; mem_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (dbg_state !== 4'd0 || mem_read !== 1'b1) begin
      n_err++; $display("FAIL reset_release got=%0d/%b exp=0/1", dbg_state, mem_read);
    end
    $display("reset: state=%0d mem_read=%b", dbg_state, mem_read);
  endtask

  task automatic test_fetch_wait_jump();
    logic [3:0] exp_s [5];
    logic       rdy   [5];
    exp_s = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd9};
    rdy   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    opcode = 6'b000010;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i]; #1;
      n_cmp++;
      if (dbg_state !== exp_s[i]) begin n_err++; $display("FAIL jwait_state[%0d] got=%0d exp=%0d", i, dbg_state, exp_s[i]); end
      if (exp_s[i] == 4'd0) begin
        n_cmp++;
        if (pc_write !== rdy[i] || ir_write !== rdy[i]) begin
          n_err++; $display("FAIL jwait_fetch_strobe[%0d] got=%b%b exp=%b%b", i, pc_write, ir_write, rdy[i], rdy[i]);
        end
      end
      if (exp_s[i] == 4'd9) begin
        n_cmp++;
        if ({pc_write, pc_source, instr_done} !== 4'b1_10_1) begin
          n_err++; $display("FAIL jump_out got=%b exp=1101", {pc_write, pc_source, instr_done});
        end
      end
      @(negedge clk);
    end
    #1; n_cmp++;
    if (dbg_state !== 4'd0) begin n_err++; $display("FAIL jwait_end got=%0d exp=0", dbg_state); end
    $display("j with fetch wait: end state=%0d", dbg_state);
  endtask

  task automatic test_rtype();
    logic [3:0] exp_s [4];
    int done_cnt = 0;
    exp_s = '{4'd0, 4'd1, 4'd6, 4'd7};
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; n_cmp++;
      if (dbg_state !== exp_s[i]) begin n_err++; $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, dbg_state, exp_s[i]); end
      if (exp_s[i] == 4'd6) begin
        n_cmp++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b1_00_10) begin
          n_err++; $display("FAIL rtype_exec got=%b exp=10010", {alu_src_a, alu_src_b, alu_op});
        end
      end
      if (exp_s[i] == 4'd7) begin
        n_cmp++;
        if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
          n_err++; $display("FAIL rtype_rwb got=%b exp=110", {reg_write, reg_dst, mem_to_reg});
        end
      end
      if (instr_done) done_cnt++;
      @(negedge clk);
    end
    #1; n_cmp++;
    if (dbg_state !== 4'd0 || done_cnt != 1) begin
      n_err++; $display("FAIL rtype_end got=%0d/%0d exp=0/1", dbg_state, done_cnt);
    end
    $display("rtype: done_cnt=%0d", done_cnt);
  endtask

  task automatic test_lw_wait();
    logic [3:0] exp_s [7];
    logic       rdy   [7];
    exp_s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    rdy   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i]; #1; n_cmp++;
      if (dbg_state !== exp_s[i]) begin n_err++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, dbg_state, exp_s[i]); end
      if (exp_s[i] == 4'd2) begin
        n_cmp++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b1_10_00) begin
          n_err++; $display("FAIL lw_memadr got=%b exp=11000", {alu_src_a, alu_src_b, alu_op});
        end
      end
      if (exp_s[i] == 4'd3) begin
        n_cmp++;
        if ({i_or_d, mem_read, instr_done} !== 3'b110) begin
          n_err++; $display("FAIL lw_memrd[%0d] got=%b exp=110", i, {i_or_d, mem_read, instr_done});
        end
      end
      if (exp_s[i] == 4'd4) begin
        n_cmp++;
        if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 4'b1011) begin
          n_err++; $display("FAIL lw_memwb got=%b exp=1011", {reg_write, reg_dst, mem_to_reg, instr_done});
        end
      end
      @(negedge clk);
    end
    #1; n_cmp++;
    if (dbg_state !== 4'd0) begin n_err++; $display("FAIL lw_end got=%0d exp=0", dbg_state); end
    $display("lw with 2 wait cycles: 7 cycles, end state=%0d", dbg_state);
  endtask

  task automatic test_sw_wait();
    logic [3:0] exp_s [5];
    logic       rdy   [5];
    exp_s = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    rdy   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i]; #1; n_cmp++;
      if (dbg_state !== exp_s[i]) begin n_err++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, dbg_state, exp_s[i]); end
      n_cmp++;
      if (mem_write !== (exp_s[i] == 4'd5) || reg_write !== 1'b0) begin
        n_err++; $display("FAIL sw_strobes[%0d] got=%b%b exp=%b0", i, mem_write, reg_write, exp_s[i] == 4'd5);
      end
      if (exp_s[i] == 4'd5) begin
        n_cmp++;
        if (instr_done !== rdy[i] || i_or_d !== 1'b1) begin
          n_err++; $display("FAIL sw_memwr[%0d] got=%b%b exp=%b1", i, instr_done, i_or_d, rdy[i]);
        end
      end
      @(negedge clk);
    end
    #1; n_cmp++;
    if (dbg_state !== 4'd0) begin n_err++; $display("FAIL sw_end got=%0d exp=0", dbg_state); end
    $display("sw with 1 wait cycle: end state=%0d", dbg_state);
  endtask

  task automatic test_addi();
    logic [3:0] exp_s [4];
    exp_s = '{4'd0, 4'd1, 4'd10, 4'd11};
    opcode = 6'b001000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; n_cmp++;
      if (dbg_state !== exp_s[i]) begin n_err++; $display("FAIL addi_state[%0d] got=%0d exp=%0d", i, dbg_state, exp_s[i]); end
      if (exp_s[i] == 4'd11) begin
        n_cmp++;
        if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 4'b1001) begin
          n_err++; $display("FAIL addi_wb got=%b exp=1001", {reg_write, reg_dst, mem_to_reg, instr_done});
        end
      end
      @(negedge clk);
    end
    $display("addi: sequence 0,1,10,11");
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; mem_ready = 1'b1;
    #1; n_cmp++;
    if (dbg_state !== 4'd0 || illegal_op !== 1'b0) begin
      n_err++; $display("FAIL illegal_fetch got=%0d/%b exp=0/0", dbg_state, illegal_op);
    end
    @(negedge clk); #1; n_cmp++;
    if (dbg_state !== 4'd1 || illegal_op !== 1'b1) begin
      n_err++; $display("FAIL illegal_decode got=%0d/%b exp=1/1", dbg_state, illegal_op);
    end
    n_cmp++;
    if ({pc_write, pc_write_cond, ir_write, mem_write, reg_write} !== 5'b0) begin
      n_err++; $display("FAIL illegal_writes got=%b exp=00000", {pc_write, pc_write_cond, ir_write, mem_write, reg_write});
    end
    @(negedge clk); #1; n_cmp++;
    if (dbg_state !== 4'd0 || illegal_op !== 1'b0) begin
      n_err++; $display("FAIL illegal_next got=%0d/%b exp=0/0", dbg_state, illegal_op);
    end
    $display("illegal opcode: returned to state %0d", dbg_state);
  endtask

  task automatic test_reset_mid_exec();
    opcode = 6'b000000; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1; n_cmp++;
    if (dbg_state !== 4'd6) begin n_err++; $display("FAIL rstmid_exec got=%0d exp=6", dbg_state); end
    rstn = 1'b0; #1; n_cmp++;
    if ({dbg_state, reg_write, mem_read, pc_write} !== 7'b0000_010) begin
      n_err++; $display("FAIL rstmid_async got=%0d/%b%b%b exp=0/010", dbg_state, reg_write, mem_read, pc_write);
    end
    @(negedge clk);
    rstn = 1'b1; mem_ready = 1'b0;
    @(negedge clk); #1; n_cmp++;
    if (dbg_state !== 4'd0 || mem_read !== 1'b1 || reg_write !== 1'b0) begin
      n_err++; $display("FAIL rstmid_release got=%0d/%b%b exp=0/10", dbg_state, mem_read, reg_write);
    end
    $display("reset mid-EXEC: state=%0d", dbg_state);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_s [8];
    logic [5:0] ops   [8];
    int done_cnt = 0;
    exp_s = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    ops   = '{6'h04, 6'h04, 6'h04, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23};
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      opcode = ops[i]; #1; n_cmp++;
      if (dbg_state !== exp_s[i]) begin n_err++; $display("FAIL b2b_state[%0d] got=%0d exp=%0d", i, dbg_state, exp_s[i]); end
      if (exp_s[i] == 4'd1) begin
        n_cmp++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b0_11_00) begin
          n_err++; $display("FAIL b2b_decode got=%b exp=01100", {alu_src_a, alu_src_b, alu_op});
        end
      end
      if (exp_s[i] == 4'd8) begin
        n_cmp++;
        if ({alu_src_a, alu_src_b, alu_op, pc_write_cond, pc_source, pc_write} !== 9'b1_00_01_1_01_0) begin
          n_err++; $display("FAIL beq_out got=%b exp=100011010", {alu_src_a, alu_src_b, alu_op, pc_write_cond, pc_source, pc_write});
        end
      end
      n_cmp++;
      if ((mem_read && mem_write) || (reg_write && pc_write)) begin
        n_err++; $display("FAIL b2b_exclusive[%0d] got=%b%b%b%b exp=no_overlap", i, mem_read, mem_write, reg_write, pc_write);
      end
      if (instr_done) done_cnt++;
      @(negedge clk);
    end
    #1; n_cmp++;
    if (dbg_state !== 4'd0 || done_cnt != 2) begin
      n_err++; $display("FAIL b2b_end got=%0d/%0d exp=0/2", dbg_state, done_cnt);
    end
    $display("beq then lw back-to-back: done_cnt=%0d", done_cnt);
  endtask

  initial begin
    rstn = 1'b0; mem_ready = 1'b0; opcode = 6'b0;
    test_reset();
    @(negedge clk);
    test_fetch_wait_jump();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_addi();
    test_illegal();
    test_reset_mid_exec();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
